// File: rtl/freq_sel_pkg.sv
// Shared types and constants for the frequency-selection front end.
// Selection range limits, selection width and controller state encoding.
package freq_sel_pkg;

  localparam int PROG_W = 3;

  localparam logic [PROG_W-1:0] PROG_MIN = 3'd0;
  localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/freq_sel_btn_debounce.sv
// Raw push-button front end: two-flop synchroniser, level debouncer and
// press (rising edge of the debounced level) detector.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_d;
  logic [CNT_W-1:0] r_cnt;

  // A new level is accepted only after it has persisted for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_db & ~r_db_d;

endmodule

// File: rtl/freq_sel_ctrl.sv
// Button-driven frequency selector: saturating 3-bit selection, one-cycle
// update pulse to the clock generator and acknowledge wait with sticky timeout.
module freq_sel_ctrl
  import freq_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [PROG_W-1:0] prog_fb,
  output logic              update,
  output logic [PROG_W-1:0] prog_sel,
  output logic              busy,
  output logic              err
);

  localparam int              TO_W    = $clog2(ACK_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PROG_W-1:0] r_sel;
  logic [PROG_W-1:0] w_sel_nxt;
  logic [TO_W-1:0]   r_tcnt;
  logic [TO_W-1:0]   w_tcnt_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_rise_up;
  logic              w_rise_dn;
  logic              w_up_ok;
  logic              w_dn_ok;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_up),
    .o_rise (w_rise_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_down),
    .o_rise (w_rise_dn)
  );

  // Simultaneous presses cancel; presses at a range limit are ignored.
  assign w_up_ok = w_rise_up & ~w_rise_dn & (r_sel != PROG_MAX);
  assign w_dn_ok = w_rise_dn & ~w_rise_up & (r_sel != PROG_MIN);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_tcnt_nxt  = r_tcnt;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_up_ok) begin
          w_sel_nxt   = r_sel + 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (w_dn_ok) begin
          w_sel_nxt   = r_sel - 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_tcnt_nxt  = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (prog_fb == r_sel) begin
          w_state_nxt = ST_IDLE;
        end else if (r_tcnt == TO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sel   <= PROG_MIN;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign update   = (r_state == ST_ISSUE);
  assign busy     = (r_state != ST_IDLE);
  assign prog_sel = r_sel;
  assign err      = r_err;

endmodule
